// File: rtl/logic_unit_pkg.sv
// Shared opcode and state encodings for the bitwise logic unit arbiter.
package logic_unit_pkg;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_NOR = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

endpackage

// File: rtl/bitwise_unit.sv
// Combinational WIDTH-bit bitwise logic unit: AND, OR, NOR, XOR.
module bitwise_unit
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            OP_AND: y = a & b;
            OP_OR:  y = a | b;
            OP_NOR: y = ~(a | b);
            OP_XOR: y = a ^ b;
        endcase
    end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one bitwise unit between two valid/ready requesters,
// with a registered, ID-tagged valid/ready result port.
module logic_unit_arbiter
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_id,
    output logic             busy
);

    // Handshake: a transfer happens on any rising edge where valid && ready are
    // both high; ready is never a function of the payload (op/a/b).
    state_e           state_q;
    logic [WIDTH-1:0] res_data_q;
    logic             res_id_q;
    logic             last_grant_q;

    logic             can_accept;
    logic             accept;
    logic             grant_id;
    logic [1:0]       op_mux;
    logic [WIDTH-1:0] a_mux;
    logic [WIDTH-1:0] b_mux;
    logic [WIDTH-1:0] unit_y;

    assign can_accept = (state_q == ST_IDLE) || res_ready;

    // Under contention the requester that did not win last time is served;
    // rst_n gating keeps both readies low while reset is asserted.
    assign req0_ready = rst_n && can_accept && req0_valid && (!req1_valid || last_grant_q);
    assign req1_ready = rst_n && can_accept && req1_valid && (!req0_valid || !last_grant_q);

    assign accept   = req0_ready || req1_ready;
    assign grant_id = req1_ready;

    assign op_mux = grant_id ? req1_op : req0_op;
    assign a_mux  = grant_id ? req1_a  : req0_a;
    assign b_mux  = grant_id ? req1_b  : req0_b;

    bitwise_unit #(.WIDTH(WIDTH)) u_bitwise_unit (
        .op (op_mux),
        .a  (a_mux),
        .b  (b_mux),
        .y  (unit_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            res_data_q   <= '0;
            res_id_q     <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_q      <= ST_HOLD;
                        res_data_q   <= unit_y;
                        res_id_q     <= grant_id;
                        last_grant_q <= grant_id;
                    end
                end
                ST_HOLD: begin
                    // A drain with a simultaneous accept reloads in place.
                    if (accept) begin
                        res_data_q   <= unit_y;
                        res_id_q     <= grant_id;
                        last_grant_q <= grant_id;
                    end else if (res_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign res_valid = (state_q == ST_HOLD);
    assign busy      = (state_q == ST_HOLD);
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Self-checking bench for logic_unit_arbiter: directed scenarios plus a result scoreboard.
module tb_logic_unit_arbiter;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst_n;
    logic             req0_valid, req1_valid;
    logic             req0_ready, req1_ready;
    logic [1:0]       req0_op, req1_op;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic             res_valid, res_ready, res_id, busy;
    logic [WIDTH-1:0] res_data;

    int checks = 0;
    int errors = 0;

    // {id, data} of every accepted operation, in acceptance order
    logic [WIDTH:0] exp_q[$];

    logic_unit_arbiter #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_id     (res_id),
        .busy       (busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] lu(input logic [1:0] op, input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return ~(a | b);
            default: return a ^ b;
        endcase
    endfunction

    // scoreboard: pop on result handshake, then push on request handshake
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (res_valid && res_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got id=%0d data=%b, expected nothing", res_id, res_data);
                end else begin
                    logic [WIDTH:0] e;
                    e = exp_q.pop_front();
                    if ({res_id, res_data} !== e) begin
                        errors++;
                        $display("FAIL sb_result: got id=%0d data=%b, expected id=%0d data=%b",
                                 res_id, res_data, e[WIDTH], e[WIDTH-1:0]);
                    end
                end
            end
            if (req0_ready || req1_ready) begin
                checks++;
                if (req0_ready && req1_ready) begin
                    errors++;
                    $display("FAIL one_ready: got req0_ready=1 req1_ready=1, expected at most one");
                end
            end
            if (req0_ready && req0_valid) exp_q.push_back({1'b0, lu(req0_op, req0_a, req0_b)});
            if (req1_ready && req1_valid) exp_q.push_back({1'b1, lu(req1_op, req1_a, req1_b)});
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_op = 2'b00; req0_a = '0; req0_b = '0;
        req1_op = 2'b00; req1_a = '0; req1_b = '0;
        res_ready = 1'b1;
    endtask

    task automatic apply_reset();
        #2 rst_n = 1'b0;
        idle_inputs();
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            req0_valid = 1'($urandom_range(0, 1)); req1_valid = 1'($urandom_range(0, 1));
            req0_op = 2'($urandom_range(0, 3)); req1_op = 2'($urandom_range(0, 3));
            req0_a = 4'($urandom_range(0, 15)); req0_b = 4'($urandom_range(0, 15));
            req1_a = 4'($urandom_range(0, 15)); req1_b = 4'($urandom_range(0, 15));
            res_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            checks++;
            if ({res_valid, res_data, res_id, busy, req0_ready, req1_ready} !== 9'b0) begin
                errors++;
                $display("FAIL reset_outputs: got valid=%b data=%b id=%b busy=%b r0=%b r1=%b, expected all 0",
                         res_valid, res_data, res_id, busy, req0_ready, req1_ready);
            end
        end
        tick();
        idle_inputs();
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if ({res_valid, res_data, res_id, busy, req0_ready, req1_ready} !== 9'b0) begin
                errors++;
                $display("FAIL post_reset_idle: got valid=%b data=%b id=%b busy=%b, expected all 0",
                         res_valid, res_data, res_id, busy);
            end
            tick();
        end
    endtask

    task automatic test_single_nor();
        req0_valid = 1'b1; req0_op = 2'b10; req0_a = 4'b1111; req0_b = 4'b1010; res_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (req0_ready !== 1'b1) begin
            errors++;
            $display("FAIL nor_ready: got req0_ready=%b, expected 1", req0_ready);
        end
        tick();
        req0_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({res_valid, busy, res_id, res_data} !== {1'b1, 1'b1, 1'b0, 4'b0000}) begin
            errors++;
            $display("FAIL nor_result: got valid=%b busy=%b id=%b data=%b, expected 1 1 0 0000",
                     res_valid, busy, res_id, res_data);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({res_valid, busy, res_data} !== {1'b0, 1'b0, 4'b0000}) begin
            errors++;
            $display("FAIL nor_drain: got valid=%b busy=%b data=%b, expected 0 0 0000",
                     res_valid, busy, res_data);
        end
    endtask

    task automatic test_contention();
        apply_reset();
        req0_valid = 1'b1; req0_op = 2'b01; req0_a = 4'b0011; req0_b = 4'b0101;
        req1_valid = 1'b1; req1_op = 2'b11; req1_a = 4'b1100; req1_b = 4'b1010;
        res_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++;
            $display("FAIL cont_first_grant: got r0=%b r1=%b, expected r0=1 r1=0", req0_ready, req1_ready);
        end
        tick();
        req0_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({res_valid, res_id, res_data, req1_ready} !== {1'b1, 1'b0, 4'b0111, 1'b1}) begin
            errors++;
            $display("FAIL cont_first_result: got valid=%b id=%b data=%b r1=%b, expected 1 0 0111 1",
                     res_valid, res_id, res_data, req1_ready);
        end
        tick();
        req1_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({res_valid, res_id, res_data} !== {1'b1, 1'b1, 4'b0110}) begin
            errors++;
            $display("FAIL cont_second_result: got valid=%b id=%b data=%b, expected 1 1 0110",
                     res_valid, res_id, res_data);
        end
        tick();
    endtask

    task automatic test_backpressure();
        req0_valid = 1'b1; req0_op = 2'b11; req0_a = 4'b1010; req0_b = 4'b0110; res_ready = 1'b1;
        tick();
        req0_valid = 1'b0; res_ready = 1'b0;
        req1_valid = 1'b1; req1_op = 2'b00; req1_a = 4'b1110; req1_b = 4'b0111;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({res_valid, res_id, res_data, req0_ready, req1_ready} !== {1'b1, 1'b0, 4'b1100, 2'b00}) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got valid=%b id=%b data=%b r0=%b r1=%b, expected 1 0 1100 0 0",
                         i, res_valid, res_id, res_data, req0_ready, req1_ready);
            end
            tick();
        end
        res_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (req1_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_ready: got req1_ready=%b, expected 1", req1_ready);
        end
        tick();
        req1_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({res_valid, res_id, res_data} !== {1'b1, 1'b1, 4'b0110}) begin
            errors++;
            $display("FAIL bp_result: got valid=%b id=%b data=%b, expected 1 1 0110",
                     res_valid, res_id, res_data);
        end
        tick();
    endtask

    task automatic test_fairness();
        apply_reset();
        req0_valid = 1'b1; req1_valid = 1'b1; res_ready = 1'b1;
        req0_op = 2'($urandom_range(0, 3)); req0_a = 4'($urandom_range(0, 15)); req0_b = 4'($urandom_range(0, 15));
        req1_op = 2'($urandom_range(0, 3)); req1_a = 4'($urandom_range(0, 15)); req1_b = 4'($urandom_range(0, 15));
        for (int i = 0; i < 6; i++) begin
            logic exp_id;
            exp_id = 1'(i % 2);
            @(negedge clk);
            checks++;
            if ({req1_ready, req0_ready} !== {exp_id, ~exp_id}) begin
                errors++;
                $display("FAIL fair_grant[%0d]: got r0=%b r1=%b, expected grant to %0d",
                         i, req0_ready, req1_ready, exp_id);
            end
            if (i > 0) begin
                checks++;
                if (res_id !== ~exp_id) begin
                    errors++;
                    $display("FAIL fair_id[%0d]: got res_id=%b, expected %b", i, res_id, ~exp_id);
                end
            end
            tick();
            if (exp_id == 1'b0) begin
                req0_op = 2'($urandom_range(0, 3)); req0_a = 4'($urandom_range(0, 15)); req0_b = 4'($urandom_range(0, 15));
            end else begin
                req1_op = 2'($urandom_range(0, 3)); req1_a = 4'($urandom_range(0, 15)); req1_b = 4'($urandom_range(0, 15));
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (res_id !== 1'b1) begin
            errors++;
            $display("FAIL fair_last_id: got res_id=%b, expected 1", res_id);
        end
        tick();
    endtask

    task automatic test_async_reset_hold();
        req1_valid = 1'b1; req1_op = 2'b01; req1_a = 4'b1000; req1_b = 4'b0001; res_ready = 1'b0;
        tick();
        req1_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b1) begin
            errors++;
            $display("FAIL ar_hold: got res_valid=%b, expected 1", res_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({res_valid, busy, res_data, res_id} !== 7'b0) begin
            errors++;
            $display("FAIL ar_immediate: got valid=%b busy=%b data=%b id=%b, expected all 0",
                     res_valid, busy, res_data, res_id);
        end
        req0_valid = 1'b1; req0_op = 2'b00; req0_a = 4'b1011; req0_b = 4'b1101;
        req1_valid = 1'b1; req1_op = 2'b11; req1_a = 4'b0101; req1_b = 4'b0011;
        res_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++;
            $display("FAIL ar_first_grant: got r0=%b r1=%b, expected r0=1 r1=0", req0_ready, req1_ready);
        end
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({res_valid, res_id, res_data} !== {1'b1, 1'b0, 4'b1001}) begin
            errors++;
            $display("FAIL ar_result: got valid=%b id=%b data=%b, expected 1 0 1001",
                     res_valid, res_id, res_data);
        end
        tick();
    endtask

    task automatic test_random();
        logic hold_m, last_m, exp_r0, exp_r1;
        apply_reset();
        hold_m = 1'b0; last_m = 1'b1;
        for (int i = 0; i < 60; i++) begin
            req0_valid = 1'($urandom_range(0, 1)); req1_valid = 1'($urandom_range(0, 1));
            req0_op = 2'($urandom_range(0, 3)); req0_a = 4'($urandom_range(0, 15)); req0_b = 4'($urandom_range(0, 15));
            req1_op = 2'($urandom_range(0, 3)); req1_a = 4'($urandom_range(0, 15)); req1_b = 4'($urandom_range(0, 15));
            res_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            exp_r0 = (!hold_m || res_ready) && req0_valid && (!req1_valid || last_m);
            exp_r1 = (!hold_m || res_ready) && req1_valid && (!req0_valid || !last_m);
            checks++;
            if ({req0_ready, req1_ready} !== {exp_r0, exp_r1} || res_valid !== hold_m) begin
                errors++;
                $display("FAIL rand_arb[%0d]: got r0=%b r1=%b valid=%b, expected r0=%b r1=%b valid=%b",
                         i, req0_ready, req1_ready, res_valid, exp_r0, exp_r1, hold_m);
            end
            if (exp_r0 || exp_r1) begin
                hold_m = 1'b1;
                last_m = exp_r1;
            end else if (res_ready) begin
                hold_m = 1'b0;
            end
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b1;
        repeat (3) tick();
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        test_reset();
        test_single_nor();
        test_contention();
        test_backpressure();
        test_fairness();
        test_async_reset_hold();
        test_random();
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d results outstanding, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
